inv_mix_columns_stage: RTL and testbench
========================================

Name: inv_mix_columns_stage

Overview:
- Decryption-side counterpart of the encrypt round stage (MixColumns plus forward key expansion).
- Takes a 128-bit state that has already been through InvShiftRows/InvSubBytes, together with the current round key.
- Performs AddRoundKey then InvMixColumns in a 2-stage pipeline.
- In parallel, performs one inverse key-expansion step and one inverse Rcon step, so stages chain into a full AES-128 decrypt datapath.

Parameters:
- PIPE_BYPASS_LAST, 1, when 1 the `last_round` input skips InvMixColumns; when 0 `last_round` is ignored.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- empty_in  input  1  1 = bubble (no valid data this cycle)
- last_round  input  1  1 = final round: AddRoundKey only, no InvMixColumns
- state_in  input  128  state, byte 0 = [127:120], column-major (bytes 0-3 = column 0)
- key_in  input  128  round key i, same byte order
- Rcon_in  input  8  Rcon value that produced key_in
- state_out  output  128  AddRoundKey result, then InvMixColumns
- key_out  output  128  round key i-1 (inverse expansion of key_in)
- Rcon_out  output  8  Rcon for the next inverse step
- empty  output  1  1 = outputs not valid

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - all pipeline registers cleared; state_out, key_out = 0; Rcon_out = 8'h00; empty = 1.
  - Reset takes priority over empty_in; in-flight data is discarded.
- Latency: exactly 2 clock edges from input sample to output, for all outputs including empty. Throughput 1 block/cycle, no stall.
- Stage 1 (edge 1), when empty_in=0:
  - s1_state = state_in ^ key_in.
  - s1_key = inverse key step of key_in, words w4..w7:
    - w3 = w7^w6, w2 = w6^w5, w1 = w5^w4.
    - w0 = w4 ^ SubWord(RotWord(w3)) ^ {Rcon_in, 24'h0}.
    - SubWord uses 4 instances of the team's existing forward S-box module.
  - s1_rcon = (Rcon_in[0]==0) ? Rcon_in>>1 : (({1'b0,Rcon_in} ^ 9'h11B) >> 1). Examples: 36→1B, 1B→80, 02→01, 01→8D.
  - s1_last = last_round.
- Stage 2 (edge 2):
  - state_out = InvMixColumns(s1_state) per column, GF(2^8) modulo x^8+x^4+x^3+x+1:
    - out0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3, with rows rotated for out1..out3.
    - If PIPE_BYPASS_LAST=1 and s1_last=1, state_out = s1_state.
  - key_out = s1_key, Rcon_out = s1_rcon.
- Bubble handling:
  - empty_in=1: stage-1 data registers hold their old values; only the empty flag advances (stage 2 empty=1 two edges later). Data outputs are don't-care while empty=1, but must hold, not toggle.
  - Back-to-back valid inputs: every cycle produces a result, with no drop or duplication.
  - Valid/bubble alternation: empty follows empty_in delayed by exactly 2 cycles.
- Reset mid-operation: on the edge after reset is deasserted, both stages are empty. The first valid output appears 2 edges after the first valid input sampled with reset=0.
- No combinational path from inputs to outputs; all outputs come from registers.

Test Plan:
1. Reset for 3 cycles with random inputs → state_out=0, key_out=0, Rcon_out=00, empty=1 throughout, and for 2 cycles after release with empty_in=1.
2. key_in=0, Rcon_in=01, state_in = column 8e4da1bc repeated 4x, last_round=0 → after 2 edges, state_out = db135345 repeated 4x, empty=0.
3. key_in = a0fafe17 88542cb1 23a33939 2a6c7605, Rcon_in=01 → key_out = 2b7e1516 28aed2a6 abf71588 09cf4f3c, Rcon_out=8D. Also Rcon_in=36 → Rcon_out=1B, and Rcon_in=1B → Rcon_out=80.
4. last_round=1, state_in=00112233…ff, key_in=000102…0f → state_out = state_in^key_in (00102030…f0), InvMixColumns skipped. Same with PIPE_BYPASS_LAST=0 → InvMixColumns applied.
5. 5 consecutive vectors with empty_in pattern 0,0,1,0,0 → empty pattern 0,0,1,0,0 shifted 2 cycles. The 4 valid results are in order, with no duplicate; data outputs are held during the bubble.
6. Reset asserted for one edge while 2 valid blocks are in flight → both discarded, empty=1 for 2 cycles, next valid input emerges with correct result after 2 edges.

Source files
------------

// File: rtl/inv_mix_columns_stage.sv
// inv_mix_columns_stage: AES-128 decrypt round stage (AddRoundKey + InvMixColumns, inverse key/Rcon step)
// Ports: clock/reset (sync, active-high); empty_in/empty bubble flags in/out;
// last_round skips InvMixColumns when PIPE_BYPASS_LAST=1; state_in/key_in/Rcon_in
// in, state_out/key_out/Rcon_out out, byte 0 at [127:120], column-major.
package inv_mix_columns_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? t : 8'h00;
      t = xt(t);
    end
    return p;
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
endpackage

module aes_sbox
  import inv_mix_columns_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;
  // multiplicative inverse as a^254 (maps 0 to 0), then the affine transform
  always_comb begin
    p2   = gmul(a_i, a_i);
    p4   = gmul(p2, p2);
    p8   = gmul(p4, p4);
    p16  = gmul(p8, p8);
    p32  = gmul(p16, p16);
    p64  = gmul(p32, p32);
    p128 = gmul(p64, p64);
    inv  = gmul(gmul(gmul(p2, p4), gmul(p8, p16)), gmul(gmul(p32, p64), p128));
    s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module inv_mix_columns_stage
  import inv_mix_columns_pkg::*;
#(
  parameter int PIPE_BYPASS_LAST = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         empty_in,
  input  logic         last_round,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   Rcon_in,
  output logic [127:0] state_out,
  output logic [127:0] key_out,
  output logic [7:0]   Rcon_out,
  output logic         empty
);
  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7, rot, sub;
  logic [127:0] key_d, imc, state_d;
  logic [7:0]   rcon_d;
  logic [127:0] s1_state_q, s1_key_q, state_q, key_q;
  logic [7:0]   s1_rcon_q, rcon_q;
  logic         s1_last_q, s1_empty_q, empty_q;
  assign {w4, w5, w6, w7} = key_in;
  assign w3  = w7 ^ w6;
  assign w2  = w6 ^ w5;
  assign w1  = w5 ^ w4;
  assign rot = {w3[23:0], w3[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_sb
    aes_sbox u_sb (.a_i(rot[8*g +: 8]), .s_o(sub[8*g +: 8]));
  end
  assign w0    = w4 ^ sub ^ {Rcon_in, 24'h0};
  assign key_d = {w0, w1, w2, w3};
  // halving in GF(2^8): odd values first add the modulus 0x11B, whose >>1 is 0x8D
  assign rcon_d = Rcon_in[0] ? ({1'b0, Rcon_in[7:1]} ^ 8'h8d) : {1'b0, Rcon_in[7:1]};
  for (genvar g = 0; g < 4; g++) begin : g_imc
    assign imc[127-32*g -: 32] = inv_mix_col(s1_state_q[127-32*g -: 32]);
  end
  assign state_d = (PIPE_BYPASS_LAST != 0 && s1_last_q) ? s1_state_q : imc;
  // data registers only load on valid slots so outputs hold steady across bubbles
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_state_q <= '0;
      s1_key_q   <= '0;
      s1_rcon_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_empty_q <= 1'b1;
      state_q    <= '0;
      key_q      <= '0;
      rcon_q     <= '0;
      empty_q    <= 1'b1;
    end else begin
      s1_empty_q <= empty_in;
      empty_q    <= s1_empty_q;
      if (!empty_in) begin
        s1_state_q <= state_in ^ key_in;
        s1_key_q   <= key_d;
        s1_rcon_q  <= rcon_d;
        s1_last_q  <= last_round;
      end
      if (!s1_empty_q) begin
        state_q <= state_d;
        key_q   <= s1_key_q;
        rcon_q  <= s1_rcon_q;
      end
    end
  end
  assign state_out = state_q;
  assign key_out   = key_q;
  assign Rcon_out  = rcon_q;
  assign empty     = empty_q;
endmodule

// File: tb/tb_inv_mix_columns_stage.sv
// tb_inv_mix_columns_stage: directed-vector bench for inv_mix_columns_stage
module tb_inv_mix_columns_stage;
  logic         clk = 1'b0, rst = 1'b1, e_in = 1'b1, last = 1'b0;
  logic [127:0] st = '0, k = '0;
  logic [7:0]   rc = '0;
  logic [127:0] so1, ko1, so0, ko0;
  logic [7:0]   ro1, ro0;
  logic         em1, em0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  inv_mix_columns_stage #(.PIPE_BYPASS_LAST(1)) dut1 (
    .clock(clk), .reset(rst), .empty_in(e_in), .last_round(last), .state_in(st),
    .key_in(k), .Rcon_in(rc), .state_out(so1), .key_out(ko1), .Rcon_out(ro1), .empty(em1));
  inv_mix_columns_stage #(.PIPE_BYPASS_LAST(0)) dut0 (
    .clock(clk), .reset(rst), .empty_in(e_in), .last_round(last), .state_in(st),
    .key_in(k), .Rcon_in(rc), .state_out(so0), .key_out(ko0), .Rcon_out(ro0), .empty(em0));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic e, input logic l, input logic [127:0] s, input logic [127:0] kk, input logic [7:0] r);
    e_in = e;
    last = l;
    st   = s;
    k    = kk;
    rc   = r;
  endtask
  logic [127:0] vs[5], exps[5], expk[5];
  logic [7:0]   rcs[5], expr[5];
  logic         es[5];
  initial begin
    vs   = '{{4{32'h8e4da1bc}}, {4{32'h9fdc589d}}, 128'h0, {4{32'hd5d5d7d6}}, {4{32'h4d7ebdf8}}};
    exps = '{{4{32'hdb135345}}, {4{32'hf20a225c}}, {4{32'hf20a225c}}, {4{32'hd4d4d4d5}}, {4{32'h2d26314c}}};
    rcs  = '{8'h36, 8'h1b, 8'h00, 8'h02, 8'h01};
    expr = '{8'h1b, 8'h80, 8'h80, 8'h01, 8'h8d};
    expk = '{{32'h55636363, 96'h0}, {32'h78636363, 96'h0}, {32'h78636363, 96'h0},
             {32'h61636363, 96'h0}, {32'h62636363, 96'h0}};
    es   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            8'($urandom));
      step;
      chk("rst_state", so1, '0);
      chk("rst_key", ko1, '0);
      chk("rst_rcon", ro1, '0);
      chk("rst_empty", em1, 1);
    end
    rst = 1'b0;
    drive(1'b1, 1'b0, '0, '0, 8'h00);
    repeat (2) begin
      step;
      chk("post_rst_empty", em1, 1);
      chk("post_rst_state", so1, '0);
    end
    drive(1'b0, 1'b0, {4{32'h8e4da1bc}}, '0, 8'h01);
    step;
    e_in = 1'b1;
    step;
    chk("imc_state", so1, {4{32'hdb135345}});
    chk("imc_state_nb", so0, {4{32'hdb135345}});
    chk("imc_key", ko1, {32'h62636363, 96'h0});
    chk("imc_key_nb", ko0, {32'h62636363, 96'h0});
    chk("imc_rcon", ro1, 8'h8d);
    chk("imc_rcon_nb", ro0, 8'h8d);
    chk("imc_empty", em1, 0);
    chk("imc_empty_nb", em0, 0);
    drive(1'b0, 1'b1, '0, 128'ha0fafe17_88542cb1_23a33939_2a6c7605, 8'h01);
    step;
    drive(1'b0, 1'b1, '0, '0, 8'h36);
    step;
    chk("ks_state", so1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    chk("ks_key", ko1, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    chk("ks_rcon01", ro1, 8'h8d);
    drive(1'b0, 1'b1, '0, '0, 8'h1b);
    step;
    chk("ks_rcon36", ro1, 8'h1b);
    chk("ks_key36", ko1, {32'h55636363, 96'h0});
    e_in = 1'b1;
    step;
    chk("ks_rcon1b", ro1, 8'h80);
    chk("ks_key1b", ko1, {32'h78636363, 96'h0});
    drive(1'b0, 1'b1, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f, 8'h01);
    step;
    e_in = 1'b1;
    step;
    chk("last_bypass", so1, 128'h00102030_40506070_8090a0b0_c0d0e0f0);
    chk("last_nobypass", so0, 128'ha0f080d0_e0b0c090_20700050_60304010);
    for (int i = 0; i < 6; i++) begin
      if (i < 5 && !es[i]) drive(1'b0, 1'b0, vs[i], '0, rcs[i]);
      else drive(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
      step;
      if (i >= 1) begin
        chk($sformatf("strm_state%0d", i - 1), so1, exps[i-1]);
        chk($sformatf("strm_key%0d", i - 1), ko1, expk[i-1]);
        chk($sformatf("strm_rcon%0d", i - 1), ro1, expr[i-1]);
        chk($sformatf("strm_empty%0d", i - 1), em1, es[i-1]);
      end
    end
    step;
    chk("strm_tail_empty", em1, 1);
    drive(1'b0, 1'b0, vs[0], '0, 8'h36);
    step;
    drive(1'b0, 1'b0, vs[1], '0, 8'h1b);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_state", so1, '0);
    chk("mid_rst_key", ko1, '0);
    chk("mid_rst_rcon", ro1, '0);
    chk("mid_rst_empty", em1, 1);
    e_in = 1'b1;
    step;
    chk("mid_rst_empty1", em1, 1);
    step;
    chk("mid_rst_empty2", em1, 1);
    drive(1'b0, 1'b0, vs[3], '0, 8'h02);
    step;
    chk("mid_rst_empty3", em1, 1);
    e_in = 1'b1;
    step;
    chk("after_rst_state", so1, {4{32'hd4d4d4d5}});
    chk("after_rst_rcon", ro1, 8'h01);
    chk("after_rst_empty", em1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
